// File: rtl/multicycle_sequencer.sv
`default_nettype none
// multicycle_sequencer: RV32I multi-cycle phase controller (FETCH/DECODE/EXEC/MEM/WB)
// with memory handshakes, write-enable gating, retired counter and sticky trap.
// Revision: 1.0
module multicycle_sequencer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_halt,
  input  logic             i_insn_vld,
  input  logic             i_rd_wren,
  input  logic             i_mem_wren,
  input  logic             i_mem_rden,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  input  logic             i_dmem_ack,
  output logic             o_ir_en,
  output logic             o_mdr_en,
  output logic             o_pc_en,
  output logic             o_rd_we,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retired,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // Counter only has to reach TIMEOUT_CYC-1: that value marks the last wait cycle.
  localparam int              TMO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam bit              TMO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             tmo_wait;
  logic             trap_set;
  logic [1:0]       trap_cause_nx;
  logic             retire;
  logic             trap_q;
  logic [1:0]       trap_cause_q;
  logic [CNT_W-1:0] retired_q;

  assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
  assign tmo_wait = ((state == S_FETCH) && !i_imem_ack) ||
                    ((state == S_MEM)   && !i_dmem_ack);

  always_comb begin
    state_nx      = state;
    trap_set      = 1'b0;
    trap_cause_nx = 2'b00;
    retire        = 1'b0;
    o_imem_req    = 1'b0;
    o_ir_en       = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_mdr_en      = 1'b0;
    o_pc_en       = 1'b0;
    o_rd_we       = 1'b0;

    case (state)
      S_IDLE: begin
        if (!i_halt) begin
          state_nx = S_FETCH;
        end
      end

      S_FETCH: begin
        o_imem_req = 1'b1;
        // An ack on the final permitted wait cycle takes priority over the timeout.
        if (i_imem_ack) begin
          o_ir_en  = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo_hit) begin
          state_nx      = S_TRAP;
          trap_set      = 1'b1;
          trap_cause_nx = CAUSE_IMEM;
        end
      end

      S_DECODE: begin
        if (!i_insn_vld) begin
          state_nx      = S_TRAP;
          trap_set      = 1'b1;
          trap_cause_nx = CAUSE_ILLEGAL;
        end else begin
          state_nx = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nx = (i_mem_rden || i_mem_wren) ? S_MEM : S_WB;
      end

      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_mem_wren;
        if (i_dmem_ack) begin
          o_mdr_en = i_mem_rden;
          state_nx = S_WB;
        end else if (tmo_hit) begin
          state_nx      = S_TRAP;
          trap_set      = 1'b1;
          trap_cause_nx = CAUSE_DMEM;
        end
      end

      S_WB: begin
        o_pc_en  = 1'b1;
        o_rd_we  = i_rd_wren;
        retire   = 1'b1;
        state_nx = i_halt ? S_IDLE : S_FETCH;
      end

      S_TRAP: begin
        state_nx = S_TRAP;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Any cycle that is not a pending FETCH/MEM wait clears the counter, so it is
  // already zero on entry to either waiting state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
    end else if (tmo_wait) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
    end else if (trap_set) begin
      trap_q       <= 1'b1;
      trap_cause_q <= trap_cause_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_ONE;
    end
  end

  assign o_trap       = trap_q;
  assign o_trap_cause = trap_cause_q;
  assign o_retired    = retired_q;
  assign o_state      = state;

endmodule
`default_nettype wire
